mipi_lane_merge: RTL

MIPI_LANE_MERGE -- requirements
Module: mipi_lane_merge

---
 rtl/mipi_lane_merge.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mipi_lane_merge.sv
// rtl/mipi_lane_merge.sv - deskews per-lane MIPI byte streams and merges them into packet words.
// Header bytes are decoded from the first words; payload and CRC words are emitted with byte enables.
module mipi_lane_merge #(
    parameter int LANES      = 2,
    parameter int SKEW_DEPTH = 8,
    parameter int SKEW_MAX   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 sclk,
    input  logic                 s_rst,
    input  logic [8*LANES-1:0]   lane_byte_data,
    input  logic [LANES-1:0]     lane_byte_vld,
    output logic [8*LANES-1:0]   word_data,
    output logic                 word_vld,
    output logic [LANES-1:0]     word_keep,
    output logic                 hdr_vld,
    output logic [7:0]           data_id,
    output logic [15:0]          word_count,
    output logic                 packet_done,
    output logic                 invalid_start
);

    localparam int AW     = $clog2(SKEW_DEPTH);
    localparam int SW     = $clog2(SKEW_MAX + 1);
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam int HWORDS = 4 / LANES;

    typedef enum logic [1:0] {IDLE, SYNC, HEADER, PAYLOAD} state_t;

    state_t         r_state;
    state_t         w_next;

    logic [7:0]     r_mem [LANES][SKEW_DEPTH];
    logic [AW-1:0]  r_wr  [LANES];
    logic [AW-1:0]  r_rd  [LANES];
    logic [AW:0]    r_cnt [LANES];

    logic [SW-1:0]  r_skew;
    logic [TW-1:0]  r_tcnt;
    logic [1:0]     r_hcnt;
    logic [23:0]    r_hdr;
    logic [16:0]    r_rem;

    logic [LANES-1:0]   w_empty;
    logic [LANES-1:0]   w_full;
    logic [8*LANES-1:0] w_pop_data;
    logic [LANES-1:0]   w_keep;
    logic [23:0]        w_hdr_next;
    logic               w_all_ne;
    logic               w_all_empty;
    logic               w_ovf;
    logic               w_pop;
    logic               w_timeout;
    logic               w_last_hword;
    logic               w_short;
    logic               w_last_word;
    logic               w_err;
    logic               w_done;
    logic               w_flush;
    logic               w_hdr_fire;
    logic               w_word_fire;

    always_comb begin
        w_empty    = '0;
        w_full     = '0;
        w_pop_data = '0;
        w_keep     = '0;
        for (int k = 0; k < LANES; k++) begin
            w_empty[k]            = (r_cnt[k] == '0);
            w_full[k]             = (r_cnt[k] == (AW+1)'(SKEW_DEPTH));
            w_pop_data[8*k +: 8]  = r_mem[k][r_rd[k]];
            w_keep[k]             = (r_rem > 17'(k));
        end
    end

    assign w_all_ne     = ~|w_empty;
    assign w_all_empty  = &w_empty;
    assign w_ovf        = |(lane_byte_vld & w_full);
    assign w_pop        = w_all_ne && (r_state != IDLE);
    assign w_timeout    = ((r_state == HEADER) || (r_state == PAYLOAD)) && w_all_empty
                          && (r_tcnt == TW'(TIMEOUT - 1));
    assign w_last_hword = (r_hcnt == 2'(HWORDS - 1));
    assign w_last_word  = (r_rem <= 17'(LANES));
    assign w_short      = (w_hdr_next[5:0] < 6'h10);

    // Only DI and WC are kept; the ECC byte (index 3) is dropped unchecked.
    always_comb begin
        w_hdr_next = r_hdr;
        for (int k = 0; k < LANES; k++) begin
            if (int'(r_hcnt) * LANES + k < 3)
                w_hdr_next[8*(int'(r_hcnt)*LANES + k) +: 8] = w_pop_data[8*k +: 8];
        end
    end

    always_comb begin
        w_next      = r_state;
        w_err       = 1'b0;
        w_done      = 1'b0;
        w_hdr_fire  = 1'b0;
        w_word_fire = 1'b0;
        case (r_state)
            IDLE: begin
                if (|lane_byte_vld)
                    w_next = SYNC;
            end
            SYNC, HEADER: begin
                if (w_pop) begin
                    if (w_last_hword) begin
                        w_hdr_fire = 1'b1;
                        if (w_short)
                            w_done = 1'b1;
                        else
                            w_next = PAYLOAD;
                    end else begin
                        w_next = HEADER;
                    end
                end else if ((r_state == SYNC) && (r_skew == SW'(SKEW_MAX))) begin
                    w_err = 1'b1;
                end
                if (!w_done && (w_ovf || w_timeout))
                    w_err = 1'b1;
                if (w_err)
                    w_hdr_fire = 1'b0;
            end
            PAYLOAD: begin
                if (w_pop) begin
                    w_word_fire = 1'b1;
                    w_done      = w_last_word;
                end
                // A completed packet outranks a simultaneous overflow/timeout.
                if (!w_done && (w_ovf || w_timeout)) begin
                    w_err       = 1'b1;
                    w_word_fire = 1'b0;
                end
            end
            default: w_next = IDLE;
        endcase
        w_flush = w_err || w_done;
        if (w_flush)
            w_next = IDLE;
    end

    always_ff @(posedge sclk) begin
        for (int k = 0; k < LANES; k++) begin
            if (lane_byte_vld[k] && !w_flush)
                r_mem[k][r_wr[k]] <= lane_byte_data[8*k +: 8];
        end
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            for (int k = 0; k < LANES; k++) begin
                r_wr[k]  <= '0;
                r_rd[k]  <= '0;
                r_cnt[k] <= '0;
            end
        end else if (w_flush) begin
            for (int k = 0; k < LANES; k++) begin
                r_wr[k]  <= '0;
                r_rd[k]  <= '0;
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_byte_vld[k])
                    r_wr[k] <= r_wr[k] + 1'b1;
                if (w_pop)
                    r_rd[k] <= r_rd[k] + 1'b1;
                r_cnt[k] <= r_cnt[k] + {{AW{1'b0}}, lane_byte_vld[k]} - {{AW{1'b0}}, w_pop};
            end
        end
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_state       <= IDLE;
            r_skew        <= '0;
            r_tcnt        <= '0;
            r_hcnt        <= '0;
            r_hdr         <= '0;
            r_rem         <= '0;
            word_data     <= '0;
            word_vld      <= 1'b0;
            word_keep     <= '0;
            hdr_vld       <= 1'b0;
            data_id       <= '0;
            word_count    <= '0;
            packet_done   <= 1'b0;
            invalid_start <= 1'b0;
        end else begin
            r_state <= w_next;
            r_skew  <= (r_state == SYNC) ? r_skew + 1'b1 : '0;
            r_tcnt  <= (((r_state == HEADER) || (r_state == PAYLOAD)) && w_all_empty && !w_flush)
                       ? r_tcnt + 1'b1 : '0;
            if (w_flush || (r_state == IDLE))
                r_hcnt <= '0;
            else if (w_pop && (r_state != PAYLOAD))
                r_hcnt <= r_hcnt + 1'b1;
            if (w_pop && ((r_state == SYNC) || (r_state == HEADER)))
                r_hdr <= w_hdr_next;
            // Remaining byte count includes the two CRC bytes.
            if (w_hdr_fire && !w_short)
                r_rem <= {1'b0, w_hdr_next[23:8]} + 17'd2;
            else if (w_word_fire)
                r_rem <= w_last_word ? '0 : r_rem - 17'(LANES);
            hdr_vld       <= w_hdr_fire;
            packet_done   <= w_done;
            invalid_start <= w_err;
            word_vld      <= w_word_fire;
            if (w_hdr_fire) begin
                data_id    <= w_hdr_next[7:0];
                word_count <= w_hdr_next[23:8];
            end
            if (w_word_fire) begin
                word_data <= w_pop_data;
                word_keep <= w_keep;
            end
        end
    end

endmodule
